// File: rtl/ram_image_loader_if.sv
// Byte source, RAM port and dump stream of the image loader.
// Handshakes: byte_in moves when byte_valid && byte_ready on a rising edge, and a dump
// word moves when dump_valid && dump_ready. An MFA request holds until MFC is sampled high.
interface ram_image_loader_if #(
  parameter int ADDR_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4
);
  localparam int WW = 8 * BYTES_PER_WORD;

  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  MFA;
  logic                  RW_RAM;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WW-1:0]         mem_wdata;
  logic [WW-1:0]         mem_rdata;
  logic                  MFC;
  logic [ADDR_WIDTH-1:0] dump_addr;
  logic [WW-1:0]         dump_data;
  logic                  dump_valid;
  logic                  dump_ready;

  modport master (
    input  byte_in, byte_valid, mem_rdata, MFC, dump_ready,
    output byte_ready, MFA, RW_RAM, mem_addr, mem_wdata, dump_addr, dump_data, dump_valid
  );

  modport slave (
    output byte_in, byte_valid, mem_rdata, MFC, dump_ready,
    input  byte_ready, MFA, RW_RAM, mem_addr, mem_wdata, dump_addr, dump_data, dump_valid
  );
endinterface

// File: rtl/ram_image_loader.sv
// Loads a byte stream into RAM word by word, releases the processor for a fixed run,
// then streams every RAM word back out.
module ram_image_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int DEPTH_BYTES    = 256,
  parameter int BIG_ENDIAN     = 1,
  parameter int RUN_CYCLES     = 1490,
  parameter int MFC_TIMEOUT    = 64
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               start,
  ram_image_loader_if.master bus,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [3:0]         state_dbg_o
);
  localparam int WW    = 8 * BYTES_PER_WORD;
  localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam int TO_W  = (MFC_TIMEOUT > 1) ? $clog2(MFC_TIMEOUT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH_BYTES - BYTES_PER_WORD);
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(BYTES_PER_WORD);

  typedef enum logic [3:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_WAIT_W, S_RUN, S_READ, S_WAIT_R, S_OUT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [WW-1:0]         word_q, word_d;
  logic [WW-1:0]         rdata_q, rdata_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [RUN_W-1:0]      run_cnt_q, run_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      lane_sel;
  logic                  last_word;
  logic                  to_expired;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      word_q     <= '0;
      rdata_q    <= '0;
      byte_cnt_q <= '0;
      run_cnt_q  <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      word_q     <= word_d;
      rdata_q    <= rdata_d;
      byte_cnt_q <= byte_cnt_d;
      run_cnt_q  <= run_cnt_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
    end
  end

  assign last_word  = (ptr_q == LAST_ADDR);
  assign to_expired = (to_cnt_q == TO_W'(MFC_TIMEOUT - 1));
  // Byte k of a word lands in lane BPW-1-k when big-endian, lane k otherwise.
  assign lane_sel   = (BIG_ENDIAN != 0) ? (CNT_W'(BYTES_PER_WORD - 1) - byte_cnt_q) : byte_cnt_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    byte_cnt_d = byte_cnt_q;
    run_cnt_d  = run_cnt_q;
    to_cnt_d   = to_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_COLLECT;
          ptr_d      = '0;
          byte_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      S_COLLECT: begin
        if (bus.byte_valid) begin
          for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (lane_sel == CNT_W'(k)) word_d[k*8 +: 8] = bus.byte_in;
          end
          if (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
            state_d    = S_WRITE;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        state_d  = S_WAIT_W;
        to_cnt_d = '0;
      end
      S_WAIT_W: begin
        if (bus.MFC) begin
          if (last_word) begin
            state_d   = S_RUN;
            ptr_d     = '0;
            run_cnt_d = RUN_W'(RUN_CYCLES - 1);
          end else begin
            state_d    = S_COLLECT;
            ptr_d      = ptr_q + STEP;
            byte_cnt_d = '0;
          end
        end else if (to_expired) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (run_cnt_q == '0) state_d = S_READ;
        else                 run_cnt_d = run_cnt_q - 1'b1;
      end
      S_READ: begin
        state_d  = S_WAIT_R;
        to_cnt_d = '0;
      end
      S_WAIT_R: begin
        if (bus.MFC) begin
          state_d = S_OUT;
          rdata_d = bus.mem_rdata;
        end else if (to_expired) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_OUT: begin
        if (bus.dump_ready) begin
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            ptr_d   = ptr_q + STEP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.byte_ready = (state_q == S_COLLECT);
    bus.MFA        = (state_q inside {S_WRITE, S_WAIT_W, S_READ, S_WAIT_R});
    bus.RW_RAM     = (state_q inside {S_WRITE, S_WAIT_W});
    bus.mem_addr   = ptr_q;
    bus.mem_wdata  = word_q;
    bus.dump_valid = (state_q == S_OUT);
    bus.dump_addr  = ptr_q;
    bus.dump_data  = rdata_q;
    cpu_reset      = (state_q == S_RUN);
    busy           = !(state_q inside {S_IDLE, S_DONE});
    done           = (state_q == S_DONE);
    err            = err_q;
    state_dbg_o    = state_q;
  end
endmodule

// File: tb/tb_ram_image_loader.sv
// Big- and little-endian loaders driven in lockstep by one byte stream, each with its own
// RAM model; write, dump and run-pulse expectations are queued and checked by monitors.
module tb_ram_image_loader;
  localparam int AW    = 8;
  localparam int BPW   = 4;
  localparam int WW    = 32;
  localparam int DEPTH = 16;
  localparam int RUNC  = 10;
  localparam int TMO   = 64;
  localparam logic [3:0] ST_WAIT_W = 4'd3;
  localparam logic [3:0] ST_RUN    = 4'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       dump_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int bp_cycles = 0;
  bit blk_en = 1'b0;
  logic [AW-1:0] blk_addr = '0;
  bit cpu_seen = 1'b0;

  logic [WW-1:0] exp_be [4];
  logic [WW-1:0] exp_le [4];

  logic          byte_ready_w [2];
  logic          mfa_w [2];
  logic          rw_w [2];
  logic          cpu_w [2];
  logic          busy_w [2];
  logic          done_w [2];
  logic          err_w [2];
  logic          dv_w [2];
  logic [AW-1:0] addr_w [2];
  logic [AW-1:0] daddr_w [2];
  logic [WW-1:0] wdata_w [2];
  logic [WW-1:0] ddata_w [2];
  logic [3:0]    state_w [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_image_loader_if #(.ADDR_WIDTH(AW), .BYTES_PER_WORD(BPW)) bus ();
    logic cpu_rst, busy, done, err;
    logic [3:0] state_dbg;
    logic [WW-1:0] mem [DEPTH/BPW];
    logic mfc = 1'b0;
    int wcnt = 0;
    logic [AW+WW-1:0] exp_wr_q[$];
    logic [AW+WW-1:0] exp_dump_q[$];
    int exp_run_q[$];

    ram_image_loader #(
      .ADDR_WIDTH(AW), .BYTES_PER_WORD(BPW), .DEPTH_BYTES(DEPTH),
      .BIG_ENDIAN((g == 0) ? 1 : 0), .RUN_CYCLES(RUNC), .MFC_TIMEOUT(TMO)
    ) dut (
      .CLK(clk), .Reset(rst_n), .start(start), .bus(bus),
      .cpu_reset(cpu_rst), .busy(busy), .done(done), .err(err), .state_dbg_o(state_dbg)
    );

    assign bus.byte_in    = byte_in;
    assign bus.byte_valid = byte_valid;
    assign bus.dump_ready = dump_ready;
    assign bus.MFC        = mfc;
    assign bus.mem_rdata  = mem[bus.mem_addr[3:2]];

    assign byte_ready_w[g] = bus.byte_ready;
    assign mfa_w[g]   = bus.MFA;
    assign rw_w[g]    = bus.RW_RAM;
    assign addr_w[g]  = bus.mem_addr;
    assign wdata_w[g] = bus.mem_wdata;
    assign dv_w[g]    = bus.dump_valid;
    assign daddr_w[g] = bus.dump_addr;
    assign ddata_w[g] = bus.dump_data;
    assign cpu_w[g]   = cpu_rst;
    assign busy_w[g]  = busy;
    assign done_w[g]  = done;
    assign err_w[g]   = err;
    assign state_w[g] = state_dbg;

    // RAM model: MFC pulses high two cycles after MFA rises.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mfc  <= 1'b0;
        wcnt <= 0;
      end else if (mfc) begin
        mfc  <= 1'b0;
        wcnt <= 0;
        if (bus.MFA && bus.RW_RAM) mem[bus.mem_addr[3:2]] <= bus.mem_wdata;
      end else if (!bus.MFA) begin
        wcnt <= 0;
      end else if (!(blk_en && bus.RW_RAM && bus.mem_addr == blk_addr)) begin
        if (wcnt == 1) mfc <= 1'b1;
        wcnt <= wcnt + 1;
      end
    end

    logic mfa_prev = 1'b0, dv_prev = 1'b0, dr_prev = 1'b0, last_hs = 1'b0, mfc_last = 1'b0;
    logic [AW-1:0] da_prev = '0;
    logic [WW-1:0] dd_prev = '0;
    int run_len = 0;

    always @(negedge clk) begin
      if (rst_n) begin
        if (bus.MFA && bus.RW_RAM && !mfa_prev) begin
          if (exp_wr_q.size() == 0) chk($sformatf("g%0d wr_unexpected", g), 64'(bus.mem_addr), 64'hFFFF);
          else chk($sformatf("g%0d wr_addr_data", g), 64'({bus.mem_addr, bus.mem_wdata}), 64'(exp_wr_q.pop_front()));
        end
        if (bus.dump_valid && dv_prev && !dr_prev) begin
          chk($sformatf("g%0d dump_addr_stable", g), 64'(bus.dump_addr), 64'(da_prev));
          chk($sformatf("g%0d dump_data_stable", g), 64'(bus.dump_data), 64'(dd_prev));
        end
        if (last_hs) chk($sformatf("g%0d done_after_last", g), 64'(done), 64'd1);
        last_hs = 1'b0;
        if (bus.dump_valid && bus.dump_ready) begin
          chk($sformatf("g%0d done_at_hs", g), 64'(done), 64'd0);
          if (exp_dump_q.size() == 0) chk($sformatf("g%0d dump_unexpected", g), 64'(bus.dump_addr), 64'hFFFF);
          else chk($sformatf("g%0d dump_addr_data", g), 64'({bus.dump_addr, bus.dump_data}), 64'(exp_dump_q.pop_front()));
          if (bus.dump_addr == AW'(DEPTH - BPW)) last_hs = 1'b1;
        end
        if (mfc_last) chk($sformatf("g%0d run_start", g), 64'(cpu_rst), 64'd1);
        mfc_last = mfc && bus.RW_RAM && (bus.mem_addr == AW'(DEPTH - BPW));
        if (cpu_rst) begin
          run_len++;
          cpu_seen = 1'b1;
        end else if (run_len > 0) begin
          if (exp_run_q.size() == 0) chk($sformatf("g%0d run_unexpected", g), 64'(run_len), 64'd0);
          else chk($sformatf("g%0d run_len", g), 64'(run_len), 64'(exp_run_q.pop_front()));
          run_len = 0;
        end
      end else begin
        run_len  = 0;
        last_hs  = 1'b0;
        mfc_last = 1'b0;
      end
      mfa_prev = bus.MFA;
      dv_prev  = bus.dump_valid;
      dr_prev  = bus.dump_ready;
      da_prev  = bus.dump_addr;
      dd_prev  = bus.dump_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int nwr, input int ndump, input bit run);
    for (int k = 0; k < nwr; k++) begin
      g_dut[0].exp_wr_q.push_back({AW'(4*k), exp_be[k]});
      g_dut[1].exp_wr_q.push_back({AW'(4*k), exp_le[k]});
    end
    for (int k = 0; k < ndump; k++) begin
      g_dut[0].exp_dump_q.push_back({AW'(4*k), exp_be[k]});
      g_dut[1].exp_dump_q.push_back({AW'(4*k), exp_le[k]});
    end
    if (run) begin
      g_dut[0].exp_run_q.push_back(RUNC);
      g_dut[1].exp_run_q.push_back(RUNC);
    end
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_load(input int nbytes, input bit gaps, input bit mid_start);
    int i = 0;
    int t = 0;
    while (i < nbytes && t < 2000) begin
      byte_in    = i[7:0];
      byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      start      = (mid_start && i == 6) ? 1'b1 : 1'b0;
      if (byte_valid && byte_ready_w[0]) i++;
      step();
      t++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (i < nbytes) chk("load_bytes_accepted", 64'(i), 64'(nbytes));
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (!done_w[0] && t < budget) begin
      step();
      t++;
    end
    chk("done_reached", 64'(done_w[0]), 64'd1);
  endtask

  task automatic wait_state(input logic [3:0] st, input logic [AW-1:0] addr, input bit use_addr);
    int t = 0;
    while (!(state_w[0] == st && (!use_addr || addr_w[0] == addr)) && t < 300) begin
      step();
      t++;
    end
    chk("state_reached", 64'(state_w[0]), 64'(st));
  endtask

  task automatic check_queues_empty();
    chk("wr_q_empty_be", 64'(g_dut[0].exp_wr_q.size()), 64'd0);
    chk("wr_q_empty_le", 64'(g_dut[1].exp_wr_q.size()), 64'd0);
    chk("dump_q_empty_be", 64'(g_dut[0].exp_dump_q.size()), 64'd0);
    chk("dump_q_empty_le", 64'(g_dut[1].exp_dump_q.size()), 64'd0);
    chk("run_q_empty_be", 64'(g_dut[0].exp_run_q.size()), 64'd0);
    chk("run_q_empty_le", 64'(g_dut[1].exp_run_q.size()), 64'd0);
  endtask

  // Dump consumer: waits bp_cycles with a word on offer before taking it.
  initial begin
    int waited = 0;
    forever begin
      step();
      if (dump_ready) begin
        dump_ready = 1'b0;
        waited = 0;
      end else if (dv_w[0]) begin
        if (waited >= bp_cycles) dump_ready = 1'b1;
        else waited++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    exp_be[0] = 32'h00010203; exp_be[1] = 32'h04050607; exp_be[2] = 32'h08090A0B; exp_be[3] = 32'h0C0D0E0F;
    exp_le[0] = 32'h03020100; exp_le[1] = 32'h07060504; exp_le[2] = 32'h0B0A0908; exp_le[3] = 32'h0F0E0D0C;

    #2 rst_n = 1'b0;
    repeat (3) step();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("g%0d reset_ctrl", g),
          64'({byte_ready_w[g], mfa_w[g], rw_w[g], cpu_w[g], dv_w[g], busy_w[g], done_w[g], err_w[g]}), 64'd0);
      chk($sformatf("g%0d reset_addr", g), 64'({addr_w[g], daddr_w[g]}), 64'd0);
      chk($sformatf("g%0d reset_data", g), {wdata_w[g], ddata_w[g]}, 64'd0);
    end
    rst_n = 1'b1;
    step();

    // Plain load, run and dump in both byte orders.
    push_exp(4, 4, 1'b1);
    pulse_start();
    run_load(16, 1'b0, 1'b0);
    wait_done(500);
    check_queues_empty();

    // Dump backpressure.
    bp_cycles = 5;
    push_exp(4, 4, 1'b1);
    pulse_start();
    run_load(16, 1'b0, 1'b0);
    wait_done(1000);
    bp_cycles = 0;
    check_queues_empty();

    // Input gaps with a start pulse in the middle of the load.
    push_exp(4, 4, 1'b1);
    pulse_start();
    run_load(16, 1'b1, 1'b1);
    wait_done(500);
    check_queues_empty();

    // MFC never arrives for the second write.
    blk_en   = 1'b1;
    blk_addr = AW'(4);
    cpu_seen = 1'b0;
    push_exp(2, 0, 1'b0);
    pulse_start();
    run_load(8, 1'b0, 1'b0);
    wait_state(ST_WAIT_W, AW'(4), 1'b1);
    t0 = cyc;
    wait_done(200);
    chk("timeout_cycles", 64'(cyc - t0), 64'(TMO));
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("g%0d timeout_err", g), 64'(err_w[g]), 64'd1);
      chk($sformatf("g%0d timeout_mfa", g), 64'(mfa_w[g]), 64'd0);
    end
    chk("timeout_cpu_reset_seen", 64'(cpu_seen), 64'd0);
    blk_en = 1'b0;
    check_queues_empty();

    // Reset during RUN, then a fresh sequence from address 0.
    push_exp(4, 0, 1'b0);
    pulse_start();
    for (int g = 0; g < 2; g++) chk($sformatf("g%0d err_cleared", g), 64'(err_w[g]), 64'd0);
    run_load(16, 1'b0, 1'b0);
    wait_state(ST_RUN, '0, 1'b0);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("g%0d async_cpu_reset", g), 64'(cpu_w[g]), 64'd0);
      chk($sformatf("g%0d async_busy", g), 64'(busy_w[g]), 64'd0);
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check_queues_empty();
    push_exp(4, 4, 1'b1);
    pulse_start();
    run_load(16, 1'b0, 1'b0);
    wait_done(500);
    check_queues_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
